// File: rtl/fifo_drain_stream_if.sv
// Handshake bundle between sync_fifo's read port, the drain block and the downstream stream sink.
// The master modport is the drain block's view; slave is the FIFO/sink side.
interface fifo_drain_stream_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  rd_cs;
  logic                  rd_en;
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;

  modport master (
    input  fifo_empty,
    input  fifo_data,
    input  m_ready,
    output rd_cs,
    output rd_en,
    output m_valid,
    output m_data
  );

  modport slave (
    output fifo_empty,
    output fifo_data,
    output m_ready,
    input  rd_cs,
    input  rd_en,
    input  m_valid,
    input  m_data
  );
endinterface

// File: rtl/fifo_drain_stream.sv
// Drains sync_fifo into a valid/ready stream through a 2-entry skid buffer,
// hiding the FIFO's one-cycle read latency and counting delivered words.
module fifo_drain_stream #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  fifo_drain_stream_if.master  bus,
  output logic [CNT_WIDTH-1:0] word_count
);

  logic [1:0]            occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
  logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
  logic [CNT_WIDTH-1:0]  word_count_q, word_count_d;

  logic       pop;
  logic       push;
  logic       rd;
  logic [1:0] level_after;

  // Reading only when the post-edge level stays below 2 guarantees the in-flight word always has a slot.
  always_comb begin
    pop         = (occ_q != 2'd0) & bus.m_ready;
    push        = inflight_q;
    level_after = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    rd          = ~rst & enable & ~bus.fifo_empty & (level_after < 2'd2);
  end

  always_comb begin
    occ_d        = occ_q;
    buf0_d       = buf0_q;
    buf1_d       = buf1_q;
    inflight_d   = rd;
    word_count_d = word_count_q + {{(CNT_WIDTH-1){1'b0}}, pop};
    case ({push, pop})
      2'b10: begin
        occ_d = occ_q + 2'd1;
        if (occ_q == 2'd0) begin
          buf0_d = bus.fifo_data;
        end else begin
          buf1_d = bus.fifo_data;
        end
      end
      2'b01: begin
        occ_d  = occ_q - 2'd1;
        buf0_d = buf1_q;
      end
      2'b11: begin
        // Simultaneous push and pop: the new word queues behind whatever remains.
        if (occ_q == 2'd1) begin
          buf0_d = bus.fifo_data;
        end else begin
          buf0_d = buf1_q;
          buf1_d = bus.fifo_data;
        end
      end
      default: begin
        occ_d = occ_q;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q        <= 2'd0;
      inflight_q   <= 1'b0;
      buf0_q       <= '0;
      buf1_q       <= '0;
      word_count_q <= '0;
    end else begin
      occ_q        <= occ_d;
      inflight_q   <= inflight_d;
      buf0_q       <= buf0_d;
      buf1_q       <= buf1_d;
      word_count_q <= word_count_d;
    end
  end

  assign bus.rd_cs   = rd;
  assign bus.rd_en   = rd;
  assign bus.m_valid = (occ_q != 2'd0);
  assign bus.m_data  = buf0_q;
  assign word_count  = word_count_q;

endmodule
